// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath.
// Owns PC and architectural status and steps one stage per instruction at a time.
module seq_stage_controller #(
    parameter logic [63:0] PC_RESET    = 64'd32,
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic             mem_ack,
    input  logic [63:0]      next_pc,
    output logic [63:0]      pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // One spare bit so the width is always at least 2.
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        icode_q;
    logic [WAIT_W-1:0] wait_q;
    logic              fetch_fault;
    logic              mem_timeout;
    logic              needs_mem;

    assign fetch_fault = imem_error || !instr_valid || (icode == 4'h0);
    assign mem_timeout = (wait_q == WAIT_LAST);

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory.
    always_comb begin
        needs_mem = 1'b0;
        unique case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: needs_mem = 1'b1;
            default:                            needs_mem = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (start) state_d = StFetch;
            StFetch:     state_d = fetch_fault ? StStop : StDecode;
            StDecode:    state_d = StExecute;
            StExecute:   state_d = needs_mem ? StMemory : StWriteback;
            StMemory: begin
                if (dmem_error)       state_d = StStop;
                else if (mem_ack)     state_d = StWriteback;
                else if (mem_timeout) state_d = StStop;
            end
            StWriteback: state_d = StFetch;
            StStop:      state_d = StStop;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            icode_q   <= 4'h0;
            wait_q    <= '0;
            pc        <= PC_RESET;
            stat      <= STAT_AOK;
            fetch_en  <= 1'b0;
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            mem_en    <= 1'b0;
            wb_en     <= 1'b0;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            state_q   <= state_d;
            fetch_en  <= (state_d == StFetch);
            decode_en <= (state_d == StDecode);
            exec_en   <= (state_d == StExecute);
            mem_en    <= (state_d == StMemory);
            wb_en     <= (state_d == StWriteback);
            mem_req   <= (state_d == StMemory);
            busy      <= (state_d != StIdle) && (state_d != StStop);
            wait_q    <= (state_q == StMemory) ? wait_q + WAIT_ONE : '0;

            if (busy) cycle_cnt <= cycle_cnt + CNT_ONE;

            unique case (state_q)
                StFetch: begin
                    icode_q <= icode;
                    if (imem_error) begin
                        stat <= STAT_ADR;
                    end else if (!instr_valid) begin
                        stat <= STAT_INS;
                    end else if (icode == 4'h0) begin
                        stat      <= STAT_HLT;
                        instr_cnt <= instr_cnt + CNT_ONE;
                    end
                end
                StMemory: begin
                    if (dmem_error || (!mem_ack && mem_timeout)) stat <= STAT_ADR;
                end
                StWriteback: begin
                    pc        <= next_pc;
                    instr_cnt <= instr_cnt + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Self-checking bench for seq_stage_controller: directed scenarios plus random
// programs scored against a per-instruction timing/outcome model.
module tb_seq_stage_controller;

    localparam int CW      = 6;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    icode = 4'h1;
    logic          instr_valid = 1'b1;
    logic          imem_error = 1'b0;
    logic          dmem_error = 1'b0;
    logic          mem_ack = 1'b0;
    logic [63:0]   next_pc = 64'd0;
    logic [63:0]   pc;
    logic          fetch_en, decode_en, exec_en, mem_en, wb_en, mem_req, busy;
    logic [2:0]    stat;
    logic [CW-1:0] cycle_cnt, instr_cnt;

    seq_stage_controller #(
        .PC_RESET    (64'd32),
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .mem_ack     (mem_ack),
        .next_pc     (next_pc),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .mem_req     (mem_req),
        .stat        (stat),
        .busy        (busy),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        bit          valid;
        bit          ierr;
        int          ja;   // MEMORY cycle (1-based) carrying mem_ack, 0 = never
        int          je;   // MEMORY cycle carrying dmem_error, 0 = never
        logic [63:0] npc;
    } instr_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0]   exp_pc;
    logic [2:0]    exp_stat;
    logic [CW-1:0] exp_cc, exp_ic;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_vec();
        return {fetch_en, decode_en, exec_en, mem_en, wb_en, mem_req, busy, stat};
    endfunction

    task automatic check_idle_like(input string tag);
        check_val({tag, "_ctrl"}, ctrl_vec(), {7'b0, exp_stat});
        check_val({tag, "_pc"}, pc, exp_pc);
        check_val({tag, "_cnt"}, {cycle_cnt, instr_cnt}, {exp_cc, exp_ic});
    endtask

    task automatic junk_inputs();
        icode       = 4'($urandom);
        instr_valid = 1'($urandom);
        imem_error  = 1'($urandom);
        mem_ack     = 1'($urandom);
        dmem_error  = 1'($urandom);
    endtask

    // Leaves the bench 1 time unit after a rising edge, in IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        junk_inputs();
        @(posedge clk); #1;
        rst_n    = 1'b1;
        exp_pc   = 64'd32;
        exp_stat = 3'd1;
        exp_cc   = '0;
        exp_ic   = '0;
        check_idle_like("reset");
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives one instruction on its own schedule and checks every cycle of it.
    task automatic exec_instr(input instr_t in, output bit stopped);
        int len, j;
        bit is_mem, wb;
        logic [2:0] st_new;
        logic [4:0] en;
        is_mem = 0; wb = 0; j = 0; st_new = 3'd1;
        if (in.ierr)              begin len = 1; st_new = 3'd3; end
        else if (!in.valid)       begin len = 1; st_new = 3'd4; end
        else if (in.icode == 4'h0) begin len = 1; st_new = 3'd2; end
        else if (in.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
            is_mem = 1;
            j = TIMEOUT;
            if (in.ja != 0 && in.ja < j) j = in.ja;
            if (in.je != 0 && in.je <= j) begin j = in.je; st_new = 3'd3; end
            else if (in.ja == j)         wb = 1;
            else                          st_new = 3'd3;
            len = 3 + j + (wb ? 1 : 0);
        end else begin
            wb = 1; len = 4;
        end

        for (int k = 0; k < len; k++) begin
            junk_inputs();
            next_pc = in.npc;
            if (k == 0) begin
                icode = in.icode; instr_valid = in.valid; imem_error = in.ierr;
            end
            if (is_mem && k >= 3 && k - 2 <= j) begin
                mem_ack    = (in.ja == k - 2);
                dmem_error = (in.je == k - 2);
            end
            @(negedge clk);
            if (k == 0)                       en = 5'b10000;
            else if (k == 1)                  en = 5'b01000;
            else if (k == 2)                  en = 5'b00100;
            else if (is_mem && k < 3 + j)     en = 5'b00010;
            else                              en = 5'b00001;
            check_val("run_ctrl", ctrl_vec(), {en, en[1], 1'b1, 3'd1});
            check_val("run_pc", pc, exp_pc);
            check_val("run_cnt", {cycle_cnt, instr_cnt}, {exp_cc + CW'(k), exp_ic});
            @(posedge clk); #1;
        end

        exp_cc = exp_cc + CW'(len);
        if (wb) begin
            exp_pc = in.npc;
            exp_ic = exp_ic + 1'b1;
        end
        if (st_new == 3'd2) exp_ic = exp_ic + 1'b1;
        exp_stat = st_new;
        stopped  = (st_new != 3'd1);
    endtask

    // STOP must hold everything, including across start pulses.
    task automatic check_stop(input string tag);
        check_idle_like(tag);
        start = 1'b1;
        junk_inputs();
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b0;
        check_idle_like({tag, "_after_start"});
    endtask

    function automatic instr_t mk(input logic [3:0] ic, input bit v, input bit ie,
                                  input int ja, input int je, input logic [63:0] npc);
        instr_t r;
        r.icode = ic; r.valid = v; r.ierr = ie; r.ja = ja; r.je = je; r.npc = npc;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.icode = ($urandom_range(0, 24) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        r.valid = ($urandom_range(0, 49) != 0);
        r.ierr  = ($urandom_range(0, 59) == 0);
        r.ja    = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 5);
        r.je    = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 6) : 0;
        r.npc   = {$urandom, $urandom};
        return r;
    endfunction

    initial begin
        bit stopped;

        // Nop stream then halt.
        do_reset();
        start_pulse();
        for (int i = 0; i < 3; i++) exec_instr(mk(4'h1, 1, 0, 0, 0, exp_pc + 64'd1), stopped);
        check_val("nop_pc", pc, 64'd35);
        exec_instr(mk(4'h0, 1, 0, 0, 0, 64'd0), stopped);
        check_stop("nop_halt");

        // mrmovq acked on the 3rd MEMORY cycle.
        do_reset();
        start_pulse();
        exec_instr(mk(4'h5, 1, 0, 3, 0, 64'd42), stopped);
        check_val("mrmovq_pc", pc, 64'd42);
        check_val("mrmovq_cc", cycle_cnt, CW'(7));
        exec_instr(mk(4'h0, 1, 0, 0, 0, 64'd0), stopped);
        check_stop("mrmovq_halt");

        // Halt as the first instruction.
        do_reset();
        start_pulse();
        exec_instr(mk(4'h0, 1, 0, 0, 0, 64'd77), stopped);
        check_stop("halt_first");

        // Fetch errors.
        do_reset();
        start_pulse();
        exec_instr(mk(4'h1, 0, 1, 0, 0, 64'd5), stopped);
        check_stop("imem_err");
        do_reset();
        start_pulse();
        exec_instr(mk(4'h1, 0, 0, 0, 0, 64'd5), stopped);
        check_stop("ins_err");

        // ret never acked: timeout.
        do_reset();
        start_pulse();
        exec_instr(mk(4'h9, 1, 0, 0, 0, 64'd50), stopped);
        check_stop("mem_timeout");

        // dmem_error and mem_ack together.
        do_reset();
        start_pulse();
        exec_instr(mk(4'hA, 1, 0, 2, 2, 64'd50), stopped);
        check_stop("dmem_err_vs_ack");

        // Reset during the 2nd MEMORY cycle.
        do_reset();
        start_pulse();
        exec_instr(mk(4'h1, 1, 0, 0, 0, 64'd99), stopped);
        for (int k = 0; k < 5; k++) begin
            junk_inputs();
            mem_ack = 1'b0; dmem_error = 1'b0;
            if (k == 0) begin icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0; end
            if (k == 4) rst_n = 1'b0;
            @(negedge clk);
            if (k == 3) check_val("mid_mem_req", mem_req, 1'b1);
            @(posedge clk); #1;
        end
        rst_n    = 1'b1;
        exp_pc   = 64'd32;
        exp_stat = 3'd1;
        exp_cc   = '0;
        exp_ic   = '0;
        check_idle_like("mid_mem_reset");

        // Random programs.
        for (int p = 0; p < 25; p++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) begin
                junk_inputs();
                @(posedge clk); #1;
                check_idle_like("idle_wait");
            end
            start_pulse();
            stopped = 0;
            for (int i = 0; i < 40 && !stopped; i++) exec_instr(rand_instr(), stopped);
            if (!stopped) exec_instr(mk(4'h0, 1, 0, 0, 0, 64'd0), stopped);
            check_stop("rand_stop");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
